// File: rtl/stencil_ctrl_pkg.sv
// Shared types and defaults for the stencil stream controller and its tag pipe.
package stencil_ctrl_pkg;

    localparam int CNT_W_DEF     = 11;
    localparam int STENCIL_W_DEF = 2;
    localparam int TOTAL_LAT_DEF = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

endpackage

// File: rtl/stencil_tag_pipe.sv
// Enable-gated shift register of {valid,last} tags that shadows the datapath pipeline.
module stencil_tag_pipe
    import stencil_ctrl_pkg::*;
#(
    parameter int DEPTH = TOTAL_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic tag_in_valid,
    input  logic tag_in_last,
    output logic tag_out_valid,
    output logic tag_out_last,
    output logic empty
);

    tag_t pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (en) begin
            pipe_q[0] <= '{valid: tag_in_valid, last: tag_in_last};
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_q[i].valid) begin
                empty = 1'b0;
            end
        end
    end

    assign tag_out_valid = pipe_q[DEPTH-1].valid;
    assign tag_out_last  = pipe_q[DEPTH-1].last;

endmodule

// File: rtl/stencil_stream_ctrl.sv
// Frame sequencer: counts pixels, drives the pipeline clock enable and tags complete windows.
// Handshake: a pixel is taken when in_valid & in_ready; a result leaves when out_valid & pipe_en.
module stencil_stream_ctrl
    import stencil_ctrl_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int STENCIL_W = STENCIL_W_DEF,
    parameter int TOTAL_LAT = TOTAL_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_height,
    output logic             cfg_err,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             pipe_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [1:0]       state_dbg
);

    localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(STENCIL_W);
    localparam logic [CNT_W-1:0] X_FIRST = CNT_W'(STENCIL_W - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] x_q, y_q, w_q, h_q;
    logic             cfg_err_q;
    logic             stall, accept, cfg_ok, x_last, y_last;
    logic             tag_in_valid, tag_in_last, tag_empty;

    assign stall  = out_valid & ~out_ready;
    assign accept = in_valid & in_ready;
    assign cfg_ok = (cfg_width >= MIN_W) && (cfg_height >= ONE);
    assign x_last = (x_q == w_q - ONE);
    assign y_last = (y_q == h_q - ONE);

    // Column positions left of a full window carry a bubble tag.
    assign tag_in_valid = (state_q == RUN) && (x_q >= X_FIRST);
    assign tag_in_last  = (state_q == RUN) && x_last && y_last;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        pipe_en  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && cfg_ok) state_d = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = ~stall;
                pipe_en  = accept;
                if (accept && x_last && y_last) state_d = DRAIN;
            end
            DRAIN: begin
                busy    = 1'b1;
                pipe_en = ~stall;
                // Leave as soon as the final result transfers, so done follows it directly.
                if (tag_empty || (out_valid && out_last && pipe_en)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= (state_q == IDLE) && start && !cfg_ok;
            if ((state_q == IDLE) && start && cfg_ok) begin
                w_q <= cfg_width;
                h_q <= cfg_height;
                x_q <= '0;
                y_q <= '0;
            end else if (accept) begin
                if (x_last) begin
                    x_q <= '0;
                    y_q <= y_q + ONE;
                end else begin
                    x_q <= x_q + ONE;
                end
            end
        end
    end

    stencil_tag_pipe #(
        .DEPTH(TOTAL_LAT)
    ) u_tag_pipe (
        .clk          (clk),
        .rst          (rst),
        .en           (pipe_en),
        .tag_in_valid (tag_in_valid),
        .tag_in_last  (tag_in_last),
        .tag_out_valid(out_valid),
        .tag_out_last (out_last),
        .empty        (tag_empty)
    );

    assign cfg_err   = cfg_err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_stencil_stream_ctrl.sv
// Directed bench for stencil_stream_ctrl: frame runs with stalls, gaps, bad cfg and mid-frame reset.
module tb_stencil_stream_ctrl;

  localparam int CNT_W = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] cfg_width, cfg_height;
  logic             cfg_err, busy, done;
  logic             in_valid, in_ready, pipe_en;
  logic             out_valid, out_ready, out_last;
  logic [1:0]       state_dbg;

  stencil_stream_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_err    (cfg_err),
    .busy       (busy),
    .done       (done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pipe_en    (pipe_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard: expected out_last flag of each result in order
  logic [0:0] exp_q[$];
  int exp_n;
  int cyc = 0;
  int acc_cnt, en_cnt, lat_meas, results_cnt, stall_cnt, last_cyc, done_cyc, cfg_err_cnt;
  logic prev_stall = 1'b0;
  logic prev_last = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && lat_meas < 0 && en_cnt >= 0) lat_meas = en_cnt;
      if (in_valid && in_ready) begin
        acc_cnt++;
        if (acc_cnt == 2) en_cnt = 0;
      end
      if (pipe_en && en_cnt >= 0) en_cnt++;
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid && !out_ready) begin
        stall_cnt++;
        check("stall_in_ready", in_ready, 0);
        check("stall_pipe_en", pipe_en, 0);
      end
      prev_stall = out_valid & ~out_ready;
      prev_last  = out_last;
      if (out_valid && pipe_en) begin
        if (exp_q.size() == 0) check("extra_result", results_cnt + 1, exp_n);
        else check("result_last", out_last, exp_q.pop_front());
        results_cnt++;
        if (out_last) last_cyc = cyc;
      end
      if (done) done_cyc = cyc;
      if (cfg_err) cfg_err_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
    cyc++;
  end

  // driver tasks
  task automatic clear_counts();
    acc_cnt = 0; en_cnt = -1; lat_meas = -1; results_cnt = 0;
    stall_cnt = 0; last_cyc = -1; done_cyc = -1; cfg_err_cnt = 0;
  endtask

  task automatic run_frame(input int w, input int h, input bit toggle, input int stall_at,
                           input int busy_start_at, input string name);
    bit got_done;
    exp_n = (w - 1) * h;
    exp_q.delete();
    for (int i = 0; i < exp_n - 1; i++) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    clear_counts();
    @(posedge clk); #1;
    cfg_width = CNT_W'(w); cfg_height = CNT_W'(h);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_width = 11'd3; cfg_height = 11'd5;   // must not affect the running frame
    got_done = 1'b0;
    for (int k = 0; k < 5000 && !got_done; k++) begin
      in_valid  = toggle ? (k % 2 == 0) : 1'b1;
      out_ready = !(k >= stall_at && k < stall_at + 3);
      start     = (k == busy_start_at);
      @(negedge clk);
      if (done) got_done = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check({name, "_done_seen"}, got_done, 1);
    check({name, "_results"}, results_cnt, exp_n);
    check({name, "_exp_left"}, exp_q.size(), 0);
    check({name, "_latency"}, lat_meas, 6);
    check({name, "_done_gap"}, done_cyc - last_cyc, 1);
    check({name, "_cfg_err"}, cfg_err_cnt, 0);
    check({name, "_busy_after"}, busy, 0);
    check({name, "_done_after"}, done, 0);
    if (stall_at >= 0) check({name, "_stall_cycles"}, stall_cnt, 3);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_width = '0; cfg_height = '0;
    clear_counts();
    exp_n = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_state", state_dbg, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_pipe_en", pipe_en, 0);

    run_frame(4, 2, 1'b0, -1, -1, "basic");
    run_frame(4, 2, 1'b0, 7, -1, "stall");
    run_frame(4, 2, 1'b1, -1, 3, "toggle");

    // illegal configurations
    @(posedge clk); #1;
    cfg_width = 11'd1; cfg_height = 11'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("w1_cfg_err", cfg_err, 1);
    check("w1_busy", busy, 0);
    @(posedge clk); #1;
    check("w1_cfg_err_pulse", cfg_err, 0);
    check("w1_state", state_dbg, 0);
    cfg_width = 11'd4; cfg_height = 11'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("h0_cfg_err", cfg_err, 1);
    check("h0_busy", busy, 0);

    // reset after three accepts
    clear_counts();
    exp_q.delete();
    @(posedge clk); #1;
    cfg_width = 11'd4; cfg_height = 11'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_accepts", acc_cnt, 3);
    check("mid_rst_state", state_dbg, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_pipe_en", pipe_en, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_cfg_err", cfg_err, 0);
    run_frame(2, 1, 1'b0, -1, -1, "small");

    run_frame(2047, 1, 1'b0, -1, -1, "wide");
    check("wide_out_valid_idle", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
